// File: rtl/codeword_serializer.sv
// Parallel-to-serial framer: takes one N-bit codeword per handshake and emits it one bit per beat with sof/eof marks.
// Define SER_SKID_EN to add a one-word hold register so frames can go out back-to-back.
module codeword_serializer #(
    parameter int N         = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] codeword,
    input  logic         cw_valid,
    output logic         cw_ready,
    input  logic         ser_ready,
    output logic         ser_valid,
    output logic         ser_bit,
    output logic         ser_sof,
    output logic         ser_eof,
    output logic         busy
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  sr, sr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          in_hs, out_hs, last;

    assign in_hs     = cw_valid & cw_ready;
    assign out_hs    = ser_valid & ser_ready;
    assign last      = (cnt == LAST);
    assign busy      = (state != IDLE);
    assign ser_valid = (state == SHIFT);
    assign ser_bit   = ser_valid & (MSB_FIRST ? sr[N-1] : sr[0]);
    assign ser_sof   = ser_valid & (cnt == '0);
    assign ser_eof   = ser_valid & last;

`ifdef SER_SKID_EN
    logic [N-1:0] hold, hold_nxt;
    logic         hold_full, hold_full_nxt;

    // While shifting, the single hold slot decides whether another word fits.
    assign cw_ready = (state == IDLE) | !hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
        end
    end
`else
    assign cw_ready = (state == IDLE);
`endif

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
`ifdef SER_SKID_EN
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
`endif
        case (state)
            IDLE: begin
                if (in_hs) begin
                    sr_nxt    = codeword;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (out_hs && !last) begin
                    sr_nxt  = MSB_FIRST ? (sr << 1) : (sr >> 1);
                    cnt_nxt = cnt + CW'(1);
                end else if (out_hs) begin
`ifdef SER_SKID_EN
                    // Queued word first; otherwise a word arriving on the eof beat bypasses the hold slot.
                    if (hold_full) begin
                        sr_nxt        = hold;
                        cnt_nxt       = '0;
                        hold_full_nxt = 1'b0;
                    end else if (in_hs) begin
                        sr_nxt  = codeword;
                        cnt_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
`else
                    state_nxt = IDLE;
`endif
                end
`ifdef SER_SKID_EN
                if (in_hs && !(out_hs && last)) begin
                    hold_nxt      = codeword;
                    hold_full_nxt = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule
